// File: rtl/pulse_stretch_pkg.sv
// Shared definitions for the pulse stretcher.
//   state_e          : FSM state encoding (IDLE, STRETCH, GAP)
//   cnt_width()      : width of the shared stretch/gap down-counter
package pulse_stretch_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    STRETCH = 2'b01,
    GAP     = 2'b10
  } state_e;

  // One counter serves both phases, so it must hold the larger reload value.
  // It is never narrower than one bit.
  function automatic int cnt_width(input int stretch_cycles, input int gap_cycles);
    int w;
    w = $clog2(stretch_cycles);
    if ($clog2(gap_cycles) > w) w = $clog2(gap_cycles);
    if (w < 1) w = 1;
    return w;
  endfunction

endpackage

// File: rtl/load_down_counter.sv
// Loadable down-counter with a zero flag.
//   clk      : clock, rising edge
//   reset_n  : synchronous active-low reset, clears the count
//   load     : load load_val (wins over dec)
//   load_val : value to load
//   dec      : decrement by one; holds at zero instead of wrapping
//   count    : current count
//   zero     : high when count is zero
module load_down_counter #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             dec,
  output logic [WIDTH-1:0] count,
  output logic             zero
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_val;
    end else if (dec && (count_q != '0)) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;
  assign zero  = (count_q == '0);

endmodule

// File: rtl/pulse_stretch_fsm.sv
// Pulse stretcher: each accepted pulse_in event drives level_out high for
// STRETCH_CYCLES cycles, followed by at least GAP_CYCLES low cycles.
// One further event may be queued while busy; extra events are discarded.
//   clk       : clock, rising edge
//   reset_n   : synchronous active-low reset
//   pulse_in  : event request, one event per cycle sampled high
//   level_out : stretched level, high while in STRETCH
//   busy      : not idle, or an event is pending
//   dropped   : one-cycle flag per discarded event
module pulse_stretch_fsm #(
  parameter int STRETCH_CYCLES = 4,
  parameter int GAP_CYCLES     = 2,
  parameter bit RETRIGGER      = 1'b0
) (
  input  logic clk,
  input  logic reset_n,
  input  logic pulse_in,
  output logic level_out,
  output logic busy,
  output logic dropped
);

  import pulse_stretch_pkg::*;

  localparam int CW = cnt_width(STRETCH_CYCLES, GAP_CYCLES);
  localparam logic [CW-1:0] STRETCH_LOAD = CW'(STRETCH_CYCLES - 1);
  localparam logic [CW-1:0] GAP_LOAD     = CW'(GAP_CYCLES - 1);

  state_e state_q, state_d;
  logic   pending_q, pending_d;
  logic   dropped_q, dropped_d;

  logic          cnt_load;
  logic [CW-1:0] cnt_load_val;
  logic          cnt_dec;
  logic          cnt_zero;
  // Only the zero flag steers the FSM; the raw count is not needed here.
  logic [CW-1:0] cnt_unused;

  load_down_counter #(
    .WIDTH(CW)
  ) u_counter (
    .clk      (clk),
    .reset_n  (reset_n),
    .load     (cnt_load),
    .load_val (cnt_load_val),
    .dec      (cnt_dec),
    .count    (cnt_unused),
    .zero     (cnt_zero)
  );

  always_comb begin
    state_d      = state_q;
    pending_d    = pending_q;
    dropped_d    = 1'b0;
    cnt_load     = 1'b0;
    cnt_load_val = '0;
    cnt_dec      = 1'b0;

    case (state_q)
      IDLE: begin
        if (pulse_in) begin
          state_d      = STRETCH;
          cnt_load     = 1'b1;
          cnt_load_val = STRETCH_LOAD;
        end
      end

      STRETCH: begin
        // A retrigger reload beats the end-of-stretch exit.
        if (RETRIGGER && pulse_in) begin
          cnt_load     = 1'b1;
          cnt_load_val = STRETCH_LOAD;
        end else if (cnt_zero) begin
          state_d      = GAP;
          cnt_load     = 1'b1;
          cnt_load_val = GAP_LOAD;
        end else begin
          cnt_dec = 1'b1;
        end
        if (!RETRIGGER && pulse_in) begin
          if (pending_q) dropped_d = 1'b1;
          else           pending_d = 1'b1;
        end
      end

      GAP: begin
        if (cnt_zero) begin
          // A pulse in the last gap cycle starts the next stretch directly;
          // if an event was already pending the two merge into one.
          if (pending_q || pulse_in) begin
            state_d      = STRETCH;
            cnt_load     = 1'b1;
            cnt_load_val = STRETCH_LOAD;
          end else begin
            state_d = IDLE;
          end
          pending_d = 1'b0;
          dropped_d = pending_q && pulse_in;
        end else begin
          cnt_dec = 1'b1;
          if (pulse_in) begin
            if (pending_q) dropped_d = 1'b1;
            else           pending_d = 1'b1;
          end
        end
      end

      default: begin
        state_d   = IDLE;
        pending_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      pending_q <= 1'b0;
      dropped_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      dropped_q <= dropped_d;
    end
  end

  assign level_out = (state_q == STRETCH);
  assign busy      = (state_q != IDLE) || pending_q;
  assign dropped   = dropped_q;

endmodule

// File: tb/tb_pulse_stretch_fsm.sv
// Self-checking bench for pulse_stretch_fsm. Two instances share the same
// stimulus: dut0 with RETRIGGER=0 and dut1 with RETRIGGER=1.
module tb_pulse_stretch_fsm;

  localparam int S = 4;
  localparam int G = 2;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic pulse_in = 1'b0;
  logic level0, busy0, drop0;
  logic level1, busy1, drop1;

  always #5 clk = ~clk;

  pulse_stretch_fsm #(.STRETCH_CYCLES(S), .GAP_CYCLES(G), .RETRIGGER(1'b0)) dut0 (
    .clk(clk), .reset_n(reset_n), .pulse_in(pulse_in),
    .level_out(level0), .busy(busy0), .dropped(drop0)
  );

  pulse_stretch_fsm #(.STRETCH_CYCLES(S), .GAP_CYCLES(G), .RETRIGGER(1'b1)) dut1 (
    .clk(clk), .reset_n(reset_n), .pulse_in(pulse_in),
    .level_out(level1), .busy(busy1), .dropped(drop1)
  );

  // Expected outputs are {level_out, busy, dropped} right after the edge
  // that samples this row's inputs.
  typedef struct {
    logic       rst_n;
    logic       pulse;
    logic [2:0] exp0;
    logic [2:0] exp1;
  } vec_t;

  vec_t vecs[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // Reference model: remaining high cycles, remaining gap cycles, queued events.
  int hi_left[2];
  int lo_left[2];
  bit pend[2];
  bit drp[2];

  function automatic void add(input logic r, input logic p,
                              input logic [2:0] e0, input logic [2:0] e1);
    vec_t v;
    v.rst_n = r;
    v.pulse = p;
    v.exp0  = e0;
    v.exp1  = e1;
    vecs.push_back(v);
  endfunction

  task automatic checkOutput(input string name, input logic actual, input logic expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got %b, expected %b at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic r, input logic p);
    @(negedge clk);
    reset_n  = r;
    pulse_in = p;
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      hi_left[i] = 0;
      lo_left[i] = 0;
      pend[i]    = 1'b0;
      drp[i]     = 1'b0;
    end
  endtask

  task automatic model_step(input int i, input logic r, input logic p, input bit retrig);
    bit nd;
    nd = 1'b0;
    if (!r) begin
      hi_left[i] = 0;
      lo_left[i] = 0;
      pend[i]    = 1'b0;
    end else if (hi_left[i] > 0) begin
      if (retrig && p) begin
        hi_left[i] = S;
      end else begin
        hi_left[i] = hi_left[i] - 1;
        if (hi_left[i] == 0) lo_left[i] = G;
      end
      if (!retrig && p) begin
        if (pend[i]) nd = 1'b1;
        else         pend[i] = 1'b1;
      end
    end else if (lo_left[i] > 0) begin
      lo_left[i] = lo_left[i] - 1;
      if (lo_left[i] == 0) begin
        if (pend[i] || p) hi_left[i] = S;
        nd      = pend[i] && p;
        pend[i] = 1'b0;
      end else if (p) begin
        if (pend[i]) nd = 1'b1;
        else         pend[i] = 1'b1;
      end
    end else if (p) begin
      hi_left[i] = S;
    end
    drp[i] = nd;
  endtask

  task automatic check_vs_model(input int cyc);
    checkOutput($sformatf("rand%0d.level0", cyc), level0, hi_left[0] > 0);
    checkOutput($sformatf("rand%0d.busy0", cyc), busy0,
                (hi_left[0] > 0) || (lo_left[0] > 0) || pend[0]);
    checkOutput($sformatf("rand%0d.drop0", cyc), drop0, drp[0]);
    checkOutput($sformatf("rand%0d.level1", cyc), level1, hi_left[1] > 0);
    checkOutput($sformatf("rand%0d.busy1", cyc), busy1,
                (hi_left[1] > 0) || (lo_left[1] > 0) || pend[1]);
    checkOutput($sformatf("rand%0d.drop1", cyc), drop1, drp[1]);
  endtask

  initial begin
    int drops;
    int rises;
    logic prev_level;
    logic r;
    logic p;

    // Reset, including a pulse held high during reset that must be ignored
    add(1'b0, 1'b1, 3'b000, 3'b000);
    add(1'b0, 1'b0, 3'b000, 3'b000);
    add(1'b1, 1'b0, 3'b000, 3'b000);
    // Single pulse: 4 high, 2 gap, idle
    add(1'b1, 1'b1, 3'b110, 3'b110);
    for (int k = 0; k < 3; k++) add(1'b1, 1'b0, 3'b110, 3'b110);
    for (int k = 0; k < 2; k++) add(1'b1, 1'b0, 3'b010, 3'b010);
    add(1'b1, 1'b0, 3'b000, 3'b000);
    // Pulses two cycles apart: queued second stretch vs retrigger
    add(1'b1, 1'b1, 3'b110, 3'b110);
    add(1'b1, 1'b0, 3'b110, 3'b110);
    add(1'b1, 1'b1, 3'b110, 3'b110);
    add(1'b1, 1'b0, 3'b110, 3'b110);
    add(1'b1, 1'b0, 3'b010, 3'b110);
    add(1'b1, 1'b0, 3'b010, 3'b110);
    add(1'b1, 1'b0, 3'b110, 3'b010);
    add(1'b1, 1'b0, 3'b110, 3'b010);
    add(1'b1, 1'b0, 3'b110, 3'b000);
    add(1'b1, 1'b0, 3'b110, 3'b000);
    add(1'b1, 1'b0, 3'b010, 3'b000);
    add(1'b1, 1'b0, 3'b010, 3'b000);
    add(1'b1, 1'b0, 3'b000, 3'b000);
    // Three pulses: third discarded without retrigger
    add(1'b1, 1'b1, 3'b110, 3'b110);
    add(1'b1, 1'b0, 3'b110, 3'b110);
    add(1'b1, 1'b1, 3'b110, 3'b110);
    add(1'b1, 1'b1, 3'b111, 3'b110);
    add(1'b1, 1'b0, 3'b010, 3'b110);
    add(1'b1, 1'b0, 3'b010, 3'b110);
    add(1'b1, 1'b0, 3'b110, 3'b110);
    add(1'b1, 1'b0, 3'b110, 3'b010);
    add(1'b1, 1'b0, 3'b110, 3'b010);
    add(1'b1, 1'b0, 3'b110, 3'b000);
    add(1'b1, 1'b0, 3'b010, 3'b000);
    add(1'b1, 1'b0, 3'b010, 3'b000);
    add(1'b1, 1'b0, 3'b000, 3'b000);
    // Pulse in the final gap cycle restarts immediately
    add(1'b1, 1'b1, 3'b110, 3'b110);
    for (int k = 0; k < 3; k++) add(1'b1, 1'b0, 3'b110, 3'b110);
    add(1'b1, 1'b0, 3'b010, 3'b010);
    add(1'b1, 1'b0, 3'b010, 3'b010);
    add(1'b1, 1'b1, 3'b110, 3'b110);
    for (int k = 0; k < 3; k++) add(1'b1, 1'b0, 3'b110, 3'b110);
    add(1'b1, 1'b0, 3'b010, 3'b010);
    add(1'b1, 1'b0, 3'b010, 3'b010);
    add(1'b1, 1'b0, 3'b000, 3'b000);
    // Reset mid-stretch aborts; next pulse starts a fresh stretch
    add(1'b1, 1'b1, 3'b110, 3'b110);
    add(1'b1, 1'b0, 3'b110, 3'b110);
    add(1'b0, 1'b0, 3'b000, 3'b000);
    add(1'b1, 1'b0, 3'b000, 3'b000);
    add(1'b1, 1'b1, 3'b110, 3'b110);
    for (int k = 0; k < 3; k++) add(1'b1, 1'b0, 3'b110, 3'b110);
    add(1'b1, 1'b0, 3'b010, 3'b010);
    add(1'b1, 1'b0, 3'b010, 3'b010);
    add(1'b1, 1'b0, 3'b000, 3'b000);
    // Pending set in gap, then merged with a final-gap pulse (one drop)
    add(1'b1, 1'b1, 3'b110, 3'b110);
    for (int k = 0; k < 3; k++) add(1'b1, 1'b0, 3'b110, 3'b110);
    add(1'b1, 1'b0, 3'b010, 3'b010);
    add(1'b1, 1'b1, 3'b010, 3'b010);
    add(1'b1, 1'b1, 3'b111, 3'b111);
    for (int k = 0; k < 3; k++) add(1'b1, 1'b0, 3'b110, 3'b110);
    add(1'b1, 1'b0, 3'b010, 3'b010);
    add(1'b1, 1'b0, 3'b010, 3'b010);
    add(1'b1, 1'b0, 3'b000, 3'b000);

    $display("[TB] applying %0d table vectors", vecs.size());
    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i].rst_n, vecs[i].pulse);
      checkOutput($sformatf("vec%0d.level0", i), level0, vecs[i].exp0[2]);
      checkOutput($sformatf("vec%0d.busy0", i),  busy0,  vecs[i].exp0[1]);
      checkOutput($sformatf("vec%0d.drop0", i),  drop0,  vecs[i].exp0[0]);
      checkOutput($sformatf("vec%0d.level1", i), level1, vecs[i].exp1[2]);
      checkOutput($sformatf("vec%0d.busy1", i),  busy1,  vecs[i].exp1[1]);
      checkOutput($sformatf("vec%0d.drop1", i),  drop1,  vecs[i].exp1[0]);
    end

    // Sustained pulse_in for 20 cycles from idle: dut1 stays high throughout,
    // dut0 stretches start every 6 cycles with 15 discarded events.
    $display("[TB] sustained pulse sequence");
    applyStimulus(1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0);
    drops = 0;
    rises = 0;
    prev_level = 1'b0;
    for (int k = 0; k < 20; k++) begin
      applyStimulus(1'b1, 1'b1);
      if (drop0) drops++;
      if (level0 && !prev_level) rises++;
      prev_level = level0;
      checkOutput($sformatf("hold%0d.level1", k), level1, 1'b1);
      checkOutput($sformatf("hold%0d.drop1", k), drop1, 1'b0);
    end
    checkOutput("hold.drop0_count_is_15", drops == 15, 1'b1);
    checkOutput("hold.stretch0_count_is_4", rises == 4, 1'b1);
    for (int k = 0; k < 6; k++) begin
      applyStimulus(1'b1, 1'b0);
      checkOutput($sformatf("release%0d.level1", k), level1, k < 3);
      checkOutput($sformatf("release%0d.busy1", k), busy1, k < 5);
    end
    for (int k = 0; k < 10; k++) applyStimulus(1'b1, 1'b0);
    checkOutput("drain.busy0", busy0, 1'b0);
    checkOutput("drain.busy1", busy1, 1'b0);

    // Randomised traffic against the reference model
    $display("[TB] random sequence");
    applyStimulus(1'b0, 1'b0);
    model_reset();
    for (int c = 0; c < 3000; c++) begin
      r = ($urandom_range(0, 59) != 0);
      p = ($urandom_range(0, 99) < 35);
      applyStimulus(r, p);
      model_step(0, r, p, 1'b0);
      model_step(1, r, p, 1'b1);
      check_vs_model(c);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
